// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer onto a variable-latency req/ack bus.
// Optional posted stores: define MEM_CTRL_POSTED_WR_EN.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        err_align,
  output logic        err_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             lat_sgn;
  logic [1:0]       lat_size;
  logic [1:0]       lat_lo;

  logic             misalign_c;
  logic             tmo_c;
  logic             resp_en_c;
  logic [3:0]       strb_c;
  logic [DW-1:0]    wdata_c;
  logic [DW-1:0]    shift_c;
  logic [DW-1:0]    load_c;

  assign misalign_c = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  assign tmo_c = (state == REQ) && !bus_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MEM_CTRL_POSTED_WR_EN
  assign resp_en_c = !lat_we;
`else
  assign resp_en_c = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid && !misalign_c) state_nx = REQ;
      REQ: begin
        if (bus_ack)    state_nx = DONE;
        else if (tmo_c) state_nx = IDLE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: store lanes, load alignment, stall request
  always_comb begin
    strb_c   = 4'b0000;
    wdata_c  = '0;
    stallreq = 1'b0;
    shift_c  = bus_rdata >> {lat_lo, 3'b000};
    load_c   = shift_c;

    if (req_we) begin
      case (req_size)
        2'd0: begin
          strb_c  = 4'b0001 << req_addr[1:0];
          wdata_c = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          strb_c  = 4'b0011 << {req_addr[1], 1'b0};
          wdata_c = {2{req_wdata[15:0]}};
        end
        2'd2: begin
          strb_c  = 4'b1111;
          wdata_c = req_wdata;
        end
        default: begin
          strb_c  = 4'b0000;
          wdata_c = '0;
        end
      endcase
    end

    case (lat_size)
      2'd0:    load_c = lat_sgn ? {{24{shift_c[7]}}, shift_c[7:0]}
                                : {24'b0, shift_c[7:0]};
      2'd1:    load_c = lat_sgn ? {{16{shift_c[15]}}, shift_c[15:0]}
                                : {16'b0, shift_c[15:0]};
      default: load_c = shift_c;
    endcase

    case (state)
`ifdef MEM_CTRL_POSTED_WR_EN
      IDLE:    stallreq = req_valid && !req_we;
      REQ:     stallreq = lat_we ? req_valid : 1'b1;
`else
      IDLE:    stallreq = req_valid;
      REQ:     stallreq = 1'b1;
`endif
      DONE:    stallreq = req_valid;
      default: stallreq = 1'b0;
    endcase
  end

  // Registered bus drive, response and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_sgn     <= 1'b0;
      lat_size    <= 2'd0;
      lat_lo      <= 2'd0;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_addr    <= '0;
      bus_wstrb   <= 4'b0000;
      bus_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_rd     <= 5'd0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      resp_valid  <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && misalign_c) begin
            err_align <= 1'b1;
          end else if (req_valid) begin
            cnt       <= '0;
            lat_we    <= req_we;
            lat_sgn   <= req_signed;
            lat_size  <= req_size;
            lat_lo    <= req_addr[1:0];
            resp_rd   <= req_rd;
            bus_req   <= 1'b1;
            bus_wr    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_wstrb <= strb_c;
            bus_wdata <= wdata_c;
          end
        end
        REQ: begin
          if (bus_ack || tmo_c) begin
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= 4'b0000;
            bus_wdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // Ack in the final timeout cycle takes priority over the abort
          if (bus_ack) begin
            resp_valid <= resp_en_c;
            resp_rdata <= lat_we ? '0 : load_c;
          end else if (tmo_c) begin
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table plus timeout/reset sequences.
module tb_mem_access_ctrl;

  localparam int unsigned TMO = 4;
`ifdef MEM_CTRL_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        err_align;
  logic        err_timeout;

  mem_access_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .stallreq   (stallreq),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .err_align  (err_align),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic        bad;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] rres;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[13];
  vec_t v_last;
  int   total   = 0;
  int   bad_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata, input int dly,
                              input logic bad, input logic [3:0] strb,
                              input logic [31:0] bwdata, input logic [31:0] rres);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.dly = dly; v.bad = bad; v.strb = strb; v.bwdata = bwdata; v.rres = rres;
    return v;
  endfunction

  // Response monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin
    if (rst) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad_cnt++;
          $display("FAIL resp_unexpected actual rdata=%08h rd=%0d expected=no response",
                   resp_rdata, resp_rd);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_rd", 32'(resp_rd), 32'(mon_e.rd));
        end
      end
      if (resp_valid || err_align || err_timeout)
        chk("pulse_exclusive", 32'(int'(resp_valid) + int'(err_align) + int'(err_timeout)), 32'd1);
    end
  end

  task automatic do_vec(input vec_t v);
    logic exp_stall;
    exp_stall = !(POSTED && v.we);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    #1;
    chk("stall_idle", 32'(stallreq), 32'(exp_stall));
    if (!v.bad && exp_stall) sb.push_back('{v.rres, v.rd});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    #1;
    if (v.bad) begin
      chk("err_align", 32'(err_align), 32'd1);
      chk("no_bus_req_misalign", 32'(bus_req), 32'd0);
    end else begin
      for (int k = 0; k <= v.dly; k++) begin
        if (k > 0) @(negedge clk);
        chk("bus_req", 32'(bus_req), 32'd1);
        chk("bus_wr", 32'(bus_wr), 32'(v.we));
        chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
        chk("bus_wstrb", 32'(bus_wstrb), 32'(v.strb));
        chk("bus_wdata", bus_wdata, v.bwdata);
        chk("stall_req", 32'(stallreq), 32'(exp_stall));
        if (k == v.dly) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end
      end
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      chk("bus_req_drop", 32'(bus_req), 32'd0);
      chk("no_timeout", 32'(err_timeout), 32'd0);
      chk("stall_done", 32'(stallreq), 32'd0);
    end
    @(negedge clk);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
    chk("idle_err_align", 32'(err_align), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    //          we    sz    sg    addr          wdata         rd     rdata        dly bad   strb     bwdata        rres
    vt[0]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,       5'd5,  32'h80AA55CC, 2, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80);
    vt[1]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,       5'd6,  32'hBEEF1234, 1, 1'b0, 4'b0000, 32'h0,        32'h0000_BEEF);
    vt[2]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00A5, 5'd7, 32'h1111_1111, 3, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    vt[3]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0,       5'd1,  32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vt[4]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0,       5'd8,  32'h1234_5678, 0, 1'b0, 4'b0000, 32'h0,        32'h1234_5678);
    vt[5]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'h0,       5'd9,  32'h0000_8001, 1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001);
    vt[6]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_7002, 32'h0,       5'd10, 32'h00F0_0000, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_00F0);
    vt[7]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_8002, 32'h1234_CAFE, 5'd11, 32'h2222_2222, 1, 1'b0, 4'b1100, 32'hCAFE_CAFE, 32'h0);
    vt[8]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_9000, 32'hDEAD_BEEF, 5'd12, 32'h3333_3333, 3, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vt[9]  = mk(1'b0, 2'd3, 1'b0, 32'h0000_A000, 32'h0,       5'd2,  32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vt[10] = mk(1'b0, 2'd1, 1'b0, 32'h0000_B001, 32'h0,       5'd3,  32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vt[11] = mk(1'b0, 2'd0, 1'b1, 32'h0000_C000, 32'h0,       5'd13, 32'h0000_007F, 3, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);
    vt[12] = mk(1'b0, 2'd1, 1'b1, 32'h0000_5006, 32'h0,       5'd14, 32'hFFFE_0000, 2, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FFFE);
    v_last = mk(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,       5'd15, 32'hCAFE_F00D, 1, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D);

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_err_align", 32'(err_align), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    rst = 1'b1;

    foreach (vt[i]) do_vec(vt[i]);

    // Timeout: no ack, bus_req for exactly TMO cycles then a single err_timeout
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_D000; req_rd = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < int'(TMO); k++) begin
      if (k > 0) @(negedge clk);
      chk("tmo_bus_req_high", 32'(bus_req), 32'd1);
      chk("tmo_no_err_yet", 32'(err_timeout), 32'd0);
    end
    @(negedge clk);
    chk("tmo_bus_req_low", 32'(bus_req), 32'd0);
    chk("tmo_err_pulse", 32'(err_timeout), 32'd1);
    chk("tmo_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("tmo_err_cleared", 32'(err_timeout), 32'd0);

    // Reset asserted during the second REQ cycle aborts silently
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_E000; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_req_c1", 32'(bus_req), 32'd1);
    @(negedge clk);
    chk("rstmid_req_c2", 32'(bus_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_bus_req_drop", 32'(bus_req), 32'd0);
    @(negedge clk);
    chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_vec(v_last);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
